// File: rtl/div_repeated_sub.sv
// rtl/div_repeated_sub.sv - repeated-subtraction unsigned divider
// Optional feature macro: DIV_ZERO_DETECT_EN (early divide-by-zero exit with dz flag)

module div_pipo_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;
  state_t state_q, state_d;

  logic             a_ld, b_ld, cnt_ld, res_ld;
  logic [WIDTH-1:0] a_d, b_d, cnt_d, quot_d, rem_d;
  logic [WIDTH-1:0] a_q, b_q, cnt_q;

  div_pipo_reg #(.WIDTH(WIDTH)) u_a    (.clk(clk), .rst_n(rst_n), .ld(a_ld),   .d(a_d),    .q(a_q));
  div_pipo_reg #(.WIDTH(WIDTH)) u_b    (.clk(clk), .rst_n(rst_n), .ld(b_ld),   .d(b_d),    .q(b_q));
  div_pipo_reg #(.WIDTH(WIDTH)) u_cnt  (.clk(clk), .rst_n(rst_n), .ld(cnt_ld), .d(cnt_d),  .q(cnt_q));
  div_pipo_reg #(.WIDTH(WIDTH)) u_quot (.clk(clk), .rst_n(rst_n), .ld(res_ld), .d(quot_d), .q(quotient));
  div_pipo_reg #(.WIDTH(WIDTH)) u_rem  (.clk(clk), .rst_n(rst_n), .ld(res_ld), .d(rem_d),  .q(remainder));

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    a_ld    = 1'b0;
    a_d     = dividend;
    b_ld    = 1'b0;
    b_d     = divisor;
    cnt_ld  = 1'b0;
    cnt_d   = '0;
    res_ld  = 1'b0;
    quot_d  = cnt_q;
    rem_d   = a_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_ld    = 1'b1;
          b_ld    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_ld  = 1'b1;
        state_d = SUB;
`ifdef DIV_ZERO_DETECT_EN
        if (b_q == '0) begin
          res_ld  = 1'b1;
          quot_d  = ONES;
          dz_d    = 1'b1;
          state_d = DONE;
        end
`endif
      end
      SUB: begin
        // Q saturates at all-ones so a zero divisor still terminates
        if (a_q >= b_q && cnt_q != ONES) begin
          a_ld   = 1'b1;
          a_d    = a_q - b_q;
          cnt_ld = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          res_ld  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
`endif
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule
